mem_bus_arbiter: RTL

- Shares one single-port memory bus between the CPU instruction-fetch port and the data (lw/sw) port.
- Sequences each access as a request/ready handshake toward memory and returns a one-cycle ack with registered read data.
- Drives a stall line to the PC/IF-ID pipeline registers.
- Contention is resolved by alternating priority, data first after reset. A watchdog aborts memory accesses that never complete.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/bus_watchdog.sv | 33 +++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus arbiter: state encoding, grant ids
// and the default watchdog length.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    localparam logic GRANT_FETCH     = 1'b0;
    localparam logic GRANT_DATA      = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 16;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags an access stuck in a grant state for
// TIMEOUT cycles.
import mem_bus_pkg::*;

module bus_watchdog #(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int             CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Holds at LAST so expiry stays asserted until the next clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch and data
// ports with alternating priority, a one-cycle ack and a watchdog abort.
import mem_bus_pkg::*;

module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_ack,
    output logic [DW-1:0] o_d_rdata,
    output logic          o_err,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ready,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_stall
);

    bus_state_t    r_state;
    bus_state_t    w_next_state;
    logic          r_last_grant;
    logic          r_served;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic          w_start;
    logic          w_winner;
    logic          w_misaligned;
    logic          w_in_gnt;
    logic          w_expired;

    assign w_in_gnt = (r_state == GNT_I) || (r_state == GNT_D);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (~w_in_gnt),
        .i_count_en (w_in_gnt),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_winner     = r_last_grant;
        w_misaligned = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_if_req || i_d_req) begin
                    w_start = 1'b1;
                    // Under contention the port that was not served last wins.
                    if (i_if_req && i_d_req) begin
                        w_winner = ~r_last_grant;
                    end else begin
                        w_winner = i_d_req ? GRANT_DATA : GRANT_FETCH;
                    end
                    w_misaligned = is_misaligned((w_winner == GRANT_DATA) ?
                                                 i_d_addr[1:0] : i_if_addr[1:0]);
                    if (w_misaligned) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = (w_winner == GRANT_DATA) ? GNT_D : GNT_I;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (i_mem_ready || w_expired) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_FETCH;
            r_served     <= GRANT_FETCH;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_last_grant <= w_winner;
                r_served     <= w_winner;
                r_addr       <= (w_winner == GRANT_DATA) ? i_d_addr : i_if_addr;
                r_we         <= (w_winner == GRANT_DATA) && i_d_we;
                r_wdata      <= (w_winner == GRANT_DATA) ? i_d_wdata : '0;
                r_rdata      <= '0;
                r_err        <= w_misaligned;
            end else if (w_in_gnt) begin
                // A ready in the expiry cycle still completes the access normally.
                if (i_mem_ready) begin
                    r_rdata <= r_we ? '0 : i_mem_rdata;
                    r_err   <= 1'b0;
                end else if (w_expired) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign o_mem_req   = w_in_gnt;
    assign o_mem_we    = (r_state == GNT_D) && r_we;
    assign o_mem_addr  = w_in_gnt ? r_addr : '0;
    assign o_mem_wdata = w_in_gnt ? r_wdata : '0;

    assign o_if_ack   = (r_state == RESP) && (r_served == GRANT_FETCH);
    assign o_d_ack    = (r_state == RESP) && (r_served == GRANT_DATA);
    assign o_if_rdata = o_if_ack ? r_rdata : '0;
    assign o_d_rdata  = o_d_ack ? r_rdata : '0;
    assign o_err      = (r_state == RESP) && r_err;

    // Held low during reset so the pipeline is not frozen by a stale request.
    assign o_stall = i_rst_n && ((i_if_req && !o_if_ack) || (i_d_req && !o_d_ack));

endmodule
